// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron layer.
//   lif_state_e : layer sequencer states
//   BETA_FRAC   : fractional bits of the unsigned leak factor
//   sat_add     : signed add clamped to a caller-chosen word width
package snn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StUpdate,
    StDone
  } lif_state_e;

  localparam int unsigned BETA_FRAC = 8;

  // Adds two sign-extended words and clamps the sum to
  // [-2^(width-1), 2^(width-1)-1]. Callers keep the low width bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned width);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (width - 1));
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/lif_datapath.sv
// Combinational leaky integrate-and-fire update for a single neuron.
//   v_i, i_i       : current membrane and accumulated input current (signed)
//   beta_i         : unsigned leak factor, value/256
//   v_th_i         : signed firing threshold (>0)
//   reset_mode_i   : 0 = reset to zero after a spike, 1 = subtract threshold
//   v_next_o       : membrane value to write back
//   spike_o        : neuron fires this step
module lif_datapath
  import snn_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] v_i,
  input  logic signed [WIDTH-1:0] i_i,
  input  logic        [7:0]       beta_i,
  input  logic signed [WIDTH-1:0] v_th_i,
  input  logic                    reset_mode_i,
  output logic signed [WIDTH-1:0] v_next_o,
  output logic                    spike_o
);

  localparam int unsigned PW = WIDTH + 9;

  logic signed [PW-1:0]    v_ext;
  logic signed [PW-1:0]    beta_ext;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    leak_full;
  logic signed [WIDTH-1:0] leak;
  logic signed [31:0]      u_wide;
  logic signed [WIDTH-1:0] u;
  logic                    unused_bits;

  assign v_ext     = PW'(v_i);
  assign beta_ext  = PW'($signed({1'b0, beta_i}));
  assign prod      = v_ext * beta_ext;
  // Arithmetic shift floors toward -inf; |v*beta/256| < |v| so it fits WIDTH.
  assign leak_full = prod >>> BETA_FRAC;
  assign leak      = leak_full[WIDTH-1:0];

  assign u_wide = sat_add(32'(leak), 32'(i_i), WIDTH);
  assign u      = u_wide[WIDTH-1:0];

  assign spike_o = (u >= v_th_i);

  // u >= v_th > 0 on a spike, so u - v_th cannot overflow.
  always_comb begin
    v_next_o = u;
    if (spike_o) begin
      v_next_o = reset_mode_i ? (u - v_th_i) : '0;
    end
  end

  assign unused_bits = ^{leak_full[PW-1:WIDTH], u_wide[31:WIDTH]};

endmodule

// File: rtl/lif_layer.sv
// Time-multiplexed layer of leaky integrate-and-fire neurons.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   clear_i             : synchronous clear of all neuron state, highest priority
//   beta_i, v_th_i,
//   reset_mode_i        : leak factor, threshold, spike reset mode
//   acc_valid_i/ready_o,
//   acc_idx_i, acc_weight_i : weight accumulate port (accepted only while idle)
//   step_start_i        : run one timestep over all neurons, one per cycle
//   busy_o              : neurons are being updated
//   step_done_o         : one-cycle pulse when spikes_o/spike_count_o are new
//   spikes_o, spike_count_o : spike vector of last completed step and its popcount
//   rd_idx_i, rd_vmem_o : registered membrane readback (write-first)
module lif_layer
  import snn_pkg::*;
#(
  parameter int unsigned N_NEURONS = 16,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic        [7:0]       beta_i,
  input  logic signed [WIDTH-1:0] v_th_i,
  input  logic                    reset_mode_i,
  input  logic                    acc_valid_i,
  output logic                    acc_ready_o,
  input  logic        [IDX_W-1:0] acc_idx_i,
  input  logic signed [WIDTH-1:0] acc_weight_i,
  input  logic                    step_start_i,
  output logic                    busy_o,
  output logic                    step_done_o,
  output logic    [N_NEURONS-1:0] spikes_o,
  output logic        [IDX_W:0]   spike_count_o,
  input  logic        [IDX_W-1:0] rd_idx_i,
  output logic signed [WIDTH-1:0] rd_vmem_o
);

  lif_state_e state_q, state_d;
  logic [IDX_W-1:0] n_q, n_d;

  logic signed [WIDTH-1:0] v_q [N_NEURONS];
  logic signed [WIDTH-1:0] v_d [N_NEURONS];
  logic signed [WIDTH-1:0] i_q [N_NEURONS];
  logic signed [WIDTH-1:0] i_d [N_NEURONS];

  logic [N_NEURONS-1:0]    s_next_q, s_next_d;
  logic [N_NEURONS-1:0]    spikes_q, spikes_d;
  logic [IDX_W:0]          spike_count_q, spike_count_d;
  logic signed [WIDTH-1:0] rd_vmem_q, rd_vmem_d;

  logic signed [WIDTH-1:0] dp_v_next;
  logic                    dp_spike;
  logic signed [31:0]      acc_sum;
  logic [IDX_W:0]          pop;
  logic                    unused_acc;

  lif_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .v_i         (v_q[n_q]),
    .i_i         (i_q[n_q]),
    .beta_i      (beta_i),
    .v_th_i      (v_th_i),
    .reset_mode_i(reset_mode_i),
    .v_next_o    (dp_v_next),
    .spike_o     (dp_spike)
  );

  assign unused_acc = ^acc_sum[31:WIDTH];

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    v_d           = v_q;
    i_d           = i_q;
    s_next_d      = s_next_q;
    spikes_d      = spikes_q;
    spike_count_d = spike_count_q;
    acc_ready_o   = 1'b0;
    busy_o        = 1'b0;
    step_done_o   = 1'b0;
    acc_sum       = '0;
    pop           = '0;

    unique case (state_q)
      StIdle: begin
        acc_ready_o = 1'b1;
        if (acc_valid_i) begin
          acc_sum             = sat_add(32'(i_q[acc_idx_i]), 32'(acc_weight_i), WIDTH);
          i_d[acc_idx_i]      = acc_sum[WIDTH-1:0];
        end
        // Weight accepted on the same edge lands before neuron 0 is read.
        if (step_start_i) begin
          state_d = StUpdate;
          n_d     = '0;
        end
      end
      StUpdate: begin
        busy_o        = 1'b1;
        v_d[n_q]      = dp_v_next;
        i_d[n_q]      = '0;
        s_next_d[n_q] = dp_spike;
        if (n_q == IDX_W'(N_NEURONS - 1)) begin
          state_d = StDone;
          // Publish on the edge into DONE so spikes are valid with step_done.
          for (int k = 0; k < N_NEURONS; k++) begin
            pop = pop + {{IDX_W{1'b0}}, s_next_d[k]};
          end
          spikes_d      = s_next_d;
          spike_count_d = pop;
        end else begin
          n_d = n_q + 1'b1;
        end
      end
      StDone: begin
        step_done_o = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (clear_i) begin
      state_d       = StIdle;
      n_d           = '0;
      step_done_o   = 1'b0;
      s_next_d      = '0;
      spikes_d      = '0;
      spike_count_d = '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_d[k] = '0;
        i_d[k] = '0;
      end
    end

    // Reading the next-state array gives write-first readback.
    rd_vmem_d = v_d[rd_idx_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      n_q           <= '0;
      s_next_q      <= '0;
      spikes_q      <= '0;
      spike_count_q <= '0;
      rd_vmem_q     <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_q[k] <= '0;
        i_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      s_next_q      <= s_next_d;
      spikes_q      <= spikes_d;
      spike_count_q <= spike_count_d;
      rd_vmem_q     <= rd_vmem_d;
      v_q           <= v_d;
      i_q           <= i_d;
    end
  end

  assign spikes_o      = spikes_q;
  assign spike_count_o = spike_count_q;
  assign rd_vmem_o     = rd_vmem_q;

endmodule
